// File: rtl/pretu_pkg.sv
// rtl/pretu_pkg.sv - shared FSM states, defaults and row types for the PreTu tile controller
package pretu_pkg;

   localparam int DW_DEF  = 16;
   localparam int TCW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef logic signed [DW_DEF-1:0] elem_t;
   typedef elem_t [3:0]               row_t;
   typedef logic signed [DW_DEF:0]   out_elem_t;
   typedef out_elem_t [3:0]           out_row_t;

endpackage

// File: rtl/pretu.sv
// rtl/pretu.sv - PreTu: column-wise B^T stage of the F(2x2,3x3) Winograd input transform
module pretu #(
   parameter int DW = 16
) (
   input  logic [3:0][DW-1:0] x0,
   input  logic [3:0][DW-1:0] x1,
   input  logic [3:0][DW-1:0] x2,
   input  logic [3:0][DW-1:0] x3,
   output logic [3:0][DW:0]   y0,
   output logic [3:0][DW:0]   y1,
   output logic [3:0][DW:0]   y2,
   output logic [3:0][DW:0]   y3
);

   always_comb begin
      y0 = '0;
      y1 = '0;
      y2 = '0;
      y3 = '0;
      for (int c = 0; c < 4; c++) begin
         // one extra bit absorbs the growth of a single add/subtract of two DW-bit values
         y0[c] = {x0[c][DW-1], x0[c]} - {x2[c][DW-1], x2[c]};
         y1[c] = {x1[c][DW-1], x1[c]} + {x2[c][DW-1], x2[c]};
         y2[c] = {x2[c][DW-1], x2[c]} - {x1[c][DW-1], x1[c]};
         y3[c] = {x1[c][DW-1], x1[c]} - {x3[c][DW-1], x3[c]};
      end
   end

endmodule

// File: rtl/pretu_tile_ctrl.sv
// rtl/pretu_tile_ctrl.sv - row-streaming 4x4 tile controller around PreTu with a one-tile output register
// Optional raw-tile bypass (port cfg_bypass) when PRETU_CTRL_BYPASS_EN is defined.
module pretu_tile_ctrl
   import pretu_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int TCW = TCW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [TCW-1:0]      cfg_tiles,
`ifdef PRETU_CTRL_BYPASS_EN
   input  logic                cfg_bypass,
`endif
   output logic                busy,
   output logic                done,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0][DW-1:0]  in_row,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3:0][DW:0]    out_y0,
   output logic [3:0][DW:0]    out_y1,
   output logic [3:0][DW:0]    out_y2,
   output logic [3:0][DW:0]    out_y3,
   output logic [TCW-1:0]      out_tile_idx,
   output logic                out_last
);

   state_e                  state_q, state_d;
   logic [1:0]              row_cnt_q, row_cnt_d;
   logic [2:0][3:0][DW-1:0] rbuf_q, rbuf_d;
   logic [TCW-1:0]          cfg_tiles_q, cfg_tiles_d;
   logic [TCW-1:0]          tile_cnt_q, tile_cnt_d;
   logic [TCW-1:0]          out_idx_q, out_idx_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    done_q, done_d;
   logic [3:0][3:0][DW:0]   out_tile_q, out_tile_d;
`ifdef PRETU_CTRL_BYPASS_EN
   logic                    bypass_q, bypass_d;
`endif

   logic [3:0][DW:0]        pt_y0, pt_y1, pt_y2, pt_y3;
   logic [3:0][3:0][DW:0]   new_tile;
   logic                    in_ready_c, accept, transfer, out_hs, final_tile;

   // Row 3 is never stored: the fourth row goes straight from the port into PreTu.
   pretu #(.DW(DW)) u_pretu (
      .x0 (rbuf_q[0]),
      .x1 (rbuf_q[1]),
      .x2 (rbuf_q[2]),
      .x3 (in_row),
      .y0 (pt_y0),
      .y1 (pt_y1),
      .y2 (pt_y2),
      .y3 (pt_y3)
   );

   always_comb begin
      new_tile = {pt_y3, pt_y2, pt_y1, pt_y0};
`ifdef PRETU_CTRL_BYPASS_EN
      if (bypass_q) begin
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 3; r++) begin
               new_tile[r][c] = {rbuf_q[r][c][DW-1], rbuf_q[r][c]};
            end
            new_tile[3][c] = {in_row[c][DW-1], in_row[c]};
         end
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      rbuf_d      = rbuf_q;
      cfg_tiles_d = cfg_tiles_q;
      tile_cnt_d  = tile_cnt_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_tile_d  = out_tile_q;
      done_d      = 1'b0;
`ifdef PRETU_CTRL_BYPASS_EN
      bypass_d    = bypass_q;
`endif

      // Stall only the tile-completing row, and only while the output register cannot drain.
      in_ready_c = (state_q == RUN) && !(row_cnt_q == 2'd3 && out_valid_q && !out_ready);
      accept     = in_valid && in_ready_c;
      transfer   = accept && (row_cnt_q == 2'd3);
      out_hs     = out_valid_q && out_ready;
      final_tile = (tile_cnt_q == cfg_tiles_q - TCW'(1));

      if (out_hs) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         row_cnt_d = row_cnt_q + 2'd1;
         case (row_cnt_q)
            2'd0:    rbuf_d[0] = in_row;
            2'd1:    rbuf_d[1] = in_row;
            2'd2:    rbuf_d[2] = in_row;
            default: ;
         endcase
      end

      if (transfer) begin
         out_valid_d = 1'b1;
         out_tile_d  = new_tile;
         out_idx_d   = tile_cnt_q;
         out_last_d  = final_tile;
         tile_cnt_d  = tile_cnt_q + TCW'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               cfg_tiles_d = cfg_tiles;
               tile_cnt_d  = '0;
               row_cnt_d   = '0;
`ifdef PRETU_CTRL_BYPASS_EN
               bypass_d    = cfg_bypass;
`endif
               if (cfg_tiles != '0) begin
                  state_d = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (transfer && final_tile) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_hs && out_last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_cnt_q   <= '0;
         rbuf_q      <= '0;
         cfg_tiles_q <= '0;
         tile_cnt_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_tile_q  <= '0;
         done_q      <= 1'b0;
`ifdef PRETU_CTRL_BYPASS_EN
         bypass_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         rbuf_q      <= rbuf_d;
         cfg_tiles_q <= cfg_tiles_d;
         tile_cnt_q  <= tile_cnt_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_tile_q  <= out_tile_d;
         done_q      <= done_d;
`ifdef PRETU_CTRL_BYPASS_EN
         bypass_q    <= bypass_d;
`endif
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign in_ready     = in_ready_c;
   assign out_valid    = out_valid_q;
   assign out_y0       = out_tile_q[0];
   assign out_y1       = out_tile_q[1];
   assign out_y2       = out_tile_q[2];
   assign out_y3       = out_tile_q[3];
   assign out_tile_idx = out_idx_q;
   assign out_last     = out_last_q;

endmodule

// File: tb/tb_pretu_tile_ctrl.sv
// tb/tb_pretu_tile_ctrl.sv - randomized self-checking bench for pretu_tile_ctrl (PRETU_CTRL_BYPASS_EN aware)
module tb_pretu_tile_ctrl;
   import pretu_pkg::*;

   localparam int DW  = DW_DEF;
   localparam int TCW = TCW_DEF;

   logic           clk = 1'b0;
   logic           rst_n, start, cfg_bypass, in_valid, out_ready;
   logic [TCW-1:0] cfg_tiles;
   row_t           in_row;
   logic           busy, done, in_ready, out_valid, out_last;
   out_row_t       out_y0, out_y1, out_y2, out_y3;
   logic [TCW-1:0] out_tile_idx;

   always #5 clk = ~clk;

   pretu_tile_ctrl #(.DW(DW), .TCW(TCW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cfg_tiles    (cfg_tiles),
`ifdef PRETU_CTRL_BYPASS_EN
      .cfg_bypass   (cfg_bypass),
`endif
      .busy         (busy),
      .done         (done),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_row       (in_row),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_y0       (out_y0),
      .out_y1       (out_y1),
      .out_y2       (out_y2),
      .out_y3       (out_y3),
      .out_tile_idx (out_tile_idx),
      .out_last     (out_last)
   );

   typedef struct {
      logic [3:0][3:0][DW:0] y;
      int                    idx;
      bit                    last;
   } exp_t;

   exp_t     exp_q[$];
   int       n_pass, n_total;
   int       n_acc, n_hs, n_done, racc, tiles_in, model_cfg;
   int       ready_mode, valid_pct, ready_pct, k, release_k, acc_at_release, bogus_k;
   bit       model_byp, pend_lat, force_row0, chk_byp_row, simul_seen;
   int       rows_x[4][4];
   out_row_t byp_exp;

   // Reference: output row r is a signed combination of whole input rows (B^T applied from the left).
   task automatic model_push();
      exp_t e;
      int   a0, a1, a2, a3, r0, r1, r2, r3;
      for (int c = 0; c < 4; c++) begin
         a0 = rows_x[0][c];
         a1 = rows_x[1][c];
         a2 = rows_x[2][c];
         a3 = rows_x[3][c];
         if (model_byp) begin
            r0 = a0; r1 = a1; r2 = a2; r3 = a3;
         end else begin
            r0 = a0 - a2; r1 = a1 + a2; r2 = a2 - a1; r3 = a1 - a3;
         end
         e.y[0][c] = (DW+1)'(r0);
         e.y[1][c] = (DW+1)'(r1);
         e.y[2][c] = (DW+1)'(r2);
         e.y[3][c] = (DW+1)'(r3);
      end
      e.idx  = tiles_in;
      e.last = (tiles_in == model_cfg - 1);
      tiles_in++;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      logic [3:0][3:0][DW:0] got;
      exp_t                  e;
      bit                    hs;
      @(negedge clk);
      if (pend_lat) begin
         n_total++;
         if (out_valid !== 1'b1) $display("FAIL latency: out_valid=%b required 1 one cycle after 4th row", out_valid);
         else n_pass++;
         pend_lat = 0;
      end
      if (ready_mode == 2 && !out_ready && in_valid && n_acc == 7) begin
         n_total++;
         if (in_ready !== 1'b0) $display("FAIL bp_in_ready: in_ready=%b required 0", in_ready);
         else n_pass++;
      end
      hs = (out_valid === 1'b1) && out_ready;
      if (hs) begin
         got = {out_y3, out_y2, out_y1, out_y0};
         n_hs++;
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_tile: idx=%0d presented, none required", out_tile_idx);
         end else begin
            e = exp_q.pop_front();
            if (got !== e.y || out_tile_idx !== TCW'(e.idx) || out_last !== e.last)
               $display("FAIL tile: got y=%h idx=%0d last=%b, required y=%h idx=%0d last=%b",
                        got, out_tile_idx, out_last, e.y, e.idx, e.last);
            else n_pass++;
         end
         if (chk_byp_row && out_tile_idx == '0) begin
            n_total++;
            if (out_y0 !== byp_exp) $display("FAIL bypass_row0: out_y0=%h required %h", out_y0, byp_exp);
            else n_pass++;
         end
      end
      if (in_valid && in_ready === 1'b1) begin
         for (int c = 0; c < 4; c++) rows_x[racc][c] = int'($signed(in_row[c]));
         n_acc++;
         racc++;
         if (racc == 4) begin
            racc = 0;
            model_push();
            pend_lat = 1;
            if (hs) simul_seen = 1;
         end
      end
      if (done === 1'b1) n_done++;
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic drive_inputs();
      logic [31:0] r;
      in_valid = ($urandom_range(99) < valid_pct);
      for (int c = 0; c < 4; c++) begin
         r = $urandom;
         in_row[c] = r[DW-1:0];
      end
      if (force_row0 && n_acc == 0) in_row = {16'sd4, -16'sd3, 16'sd2, -16'sd1};
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(99) < ready_pct);
         2:       out_ready = (k >= release_k);
         default: out_ready = (n_acc >= 7);
      endcase
      if (ready_mode == 2 && k == release_k) acc_at_release = n_acc;
      start = (k == bogus_k);
      if (start) cfg_tiles = TCW'(model_cfg + 3);
   endtask

   task automatic begin_frame(input int cfg, input bit byp, input int rmode, input int vpct, input int rpct);
      model_cfg  = cfg;
      model_byp  = byp;
      tiles_in   = 0;
      racc       = 0;
      n_acc      = 0;
      n_hs       = 0;
      n_done     = 0;
      pend_lat   = 0;
      k          = 0;
      ready_mode = rmode;
      valid_pct  = vpct;
      ready_pct  = rpct;
      exp_q.delete();
      start      = 1'b1;
      cfg_tiles  = TCW'(cfg);
      cfg_bypass = byp;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      tick();
      start      = 1'b0;
      n_total++;
      if (busy !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL start_busy: busy=%b in_ready=%b required 1 1", busy, in_ready);
      else n_pass++;
   endtask

   task automatic run_frame(input int cfg, input bit byp, input int rmode, input int vpct, input int rpct);
      begin_frame(cfg, byp, rmode, vpct, rpct);
      while (n_done == 0 && k < 2000) begin
         drive_inputs();
         tick();
      end
      n_total++;
      if (n_done == 0) $display("FAIL frame_timeout: no done within %0d cycles (cfg=%0d)", k, cfg);
      else n_pass++;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      start     = 1'b0;
      repeat (3) tick();
      n_total++;
      if (n_acc != 4 * cfg || n_hs != cfg || exp_q.size() != 0)
         $display("FAIL frame_counts: rows=%0d tiles=%0d left=%0d required rows=%0d tiles=%0d left=0",
                  n_acc, n_hs, exp_q.size(), 4 * cfg, cfg);
      else n_pass++;
      n_total++;
      if (n_done != 1 || busy !== 1'b0) $display("FAIL done_once: done pulses=%0d busy=%b required 1 0", n_done, busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_total++;
      if ({busy, done, in_ready, out_valid, out_last} !== 5'b0)
         $display("FAIL reset_ctrl: busy/done/in_ready/out_valid/out_last=%b required 00000",
                  {busy, done, in_ready, out_valid, out_last});
      else n_pass++;
      n_total++;
      if ({out_y0, out_y1, out_y2, out_y3} !== '0 || out_tile_idx !== '0)
         $display("FAIL reset_data: y=%h idx=%0d required 0 0", {out_y0, out_y1, out_y2, out_y3}, out_tile_idx);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      run_frame(3, 1'b0, 0, 100, 100);
   endtask

   task automatic test_backpressure();
      release_k      = 20;
      acc_at_release = -1;
      run_frame(2, 1'b0, 2, 100, 0);
      n_total++;
      if (acc_at_release != 7) $display("FAIL bp_rows_held: rows at release=%0d required 7", acc_at_release);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      simul_seen = 0;
      run_frame(2, 1'b0, 3, 100, 0);
      n_total++;
      if (!simul_seen) $display("FAIL simul_event: drain+transfer in one cycle seen=%0d required 1", simul_seen);
      else n_pass++;
   endtask

   task automatic test_zero_cfg();
      ready_mode = 0;
      start      = 1'b1;
      cfg_tiles  = '0;
      tick();
      start = 1'b0;
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL zero_cfg: done=%b busy=%b in_ready=%b required 1 0 0", done, busy, in_ready);
      else n_pass++;
      tick();
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_cfg_after: done=%b busy=%b required 0 0", done, busy);
      else n_pass++;
   endtask

   task automatic test_bogus_start();
      bogus_k = 6;
      run_frame(2, 1'b0, 0, 100, 100);
      bogus_k = -1;
   endtask

   task automatic test_reset_mid();
      release_k = 100000;
      begin_frame(2, 1'b0, 2, 100, 0);
      while (n_acc < 6 && k < 100) begin
         drive_inputs();
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      tick();
      n_total++;
      if ({busy, done, in_ready, out_valid, out_last} !== 5'b0 || out_tile_idx !== '0 ||
          {out_y0, out_y1, out_y2, out_y3} !== '0)
         $display("FAIL mid_reset: busy/done/in_ready/out_valid/out_last=%b idx=%0d y=%h required all 0",
                  {busy, done, in_ready, out_valid, out_last}, out_tile_idx, {out_y0, out_y1, out_y2, out_y3});
      else n_pass++;
      rst_n    = 1'b1;
      pend_lat = 0;
      tick();
      run_frame(1, 1'b0, 0, 100, 100);
   endtask

   task automatic test_random();
      for (int f = 0; f < 5; f++) begin
         run_frame(int'($urandom_range(6, 1)), 1'b0, 1, 70, 60);
      end
   endtask

`ifdef PRETU_CTRL_BYPASS_EN
   task automatic test_bypass();
      byp_exp     = {17'sd4, -17'sd3, 17'sd2, -17'sd1};
      force_row0  = 1;
      chk_byp_row = 1;
      run_frame(2, 1'b1, 0, 100, 100);
      force_row0  = 0;
      chk_byp_row = 0;
      run_frame(1, 1'b0, 0, 100, 100);
   endtask
`endif

   initial begin
      n_pass      = 0;
      n_total     = 0;
      k           = 0;
      bogus_k     = -1;
      release_k   = 0;
      ready_mode  = 0;
      valid_pct   = 100;
      ready_pct   = 100;
      force_row0  = 0;
      chk_byp_row = 0;
      simul_seen  = 0;
      pend_lat    = 0;
      byp_exp     = '0;
      rst_n       = 1'b0;
      start       = 1'b0;
      cfg_tiles   = '0;
      cfg_bypass  = 1'b0;
      in_valid    = 1'b0;
      in_row      = '0;
      out_ready   = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_backpressure();
      test_simultaneous();
      test_zero_cfg();
      test_bogus_start();
      test_reset_mid();
      test_random();
`ifdef PRETU_CTRL_BYPASS_EN
      test_bypass();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
